alu_exec_unit: RTL and testbench

Execute-stage datapath slice of the 5-stage MIPS pipeline: decodes the 2-bit ALU operation class and 6-bit function field into a 4-bit ALU control code, performs the 32-bit ALU operation with zero detection, and computes the sequential PC (PC + 4). Combinational results are also captured in an enable-gated output register for the downstream pipeline register.

---
 rtl/alu_exec_unit.sv | 115 +++++++++++
 tb/tb_alu_exec_unit.sv | 278 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_exec_unit.sv
// alu_exec_unit
// Execute-stage datapath slice of a 5-stage MIPS pipeline.
//   - Decodes the 2-bit ALU operation class and the 6-bit funct field into a
//     4-bit ALU control code.
//   - Performs the 32-bit ALU operation and flags a zero result.
//   - Computes the sequential PC (pc + PC_INC).
//   - Captures result/zero/pc_plus4 in an enable-gated register that feeds the
//     downstream pipeline register.
//
// Ports:
//   clk        in   1   rising-edge clock
//   rst        in   1   asynchronous, active-low reset of the registered outputs
//   en         in   1   capture enable for the registered outputs
//   aluop      in   2   operation class from the control unit
//   func       in   6   instruction funct field
//   in1        in  32   ALU operand A
//   in2        in  32   ALU operand B
//   pc         in  32   current PC
//   aluctrl    out  4   decoded ALU control code (combinational)
//   result     out 32   ALU result (combinational)
//   zero       out  1   result == 0 (combinational)
//   pc_plus4   out 32   pc + PC_INC (combinational)
//   result_q   out 32   registered result
//   zero_q     out  1   registered zero
//   pc_plus4_q out 32   registered pc_plus4
module alu_exec_unit #(
  parameter logic [31:0] PC_INC = 32'd4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        en,
  input  logic [1:0]  aluop,
  input  logic [5:0]  func,
  input  logic [31:0] in1,
  input  logic [31:0] in2,
  input  logic [31:0] pc,
  output logic [3:0]  aluctrl,
  output logic [31:0] result,
  output logic        zero,
  output logic [31:0] pc_plus4,
  output logic [31:0] result_q,
  output logic        zero_q,
  output logic [31:0] pc_plus4_q
);

  // ALU control codes
  localparam logic [3:0] CTRL_AND = 4'b0000;
  localparam logic [3:0] CTRL_OR  = 4'b0001;
  localparam logic [3:0] CTRL_ADD = 4'b0010;
  localparam logic [3:0] CTRL_SUB = 4'b0110;
  localparam logic [3:0] CTRL_SLT = 4'b0111;
  localparam logic [3:0] CTRL_NOR = 4'b1100;
  localparam logic [3:0] CTRL_BAD = 4'b1111;

  // R-type funct encodings
  localparam logic [5:0] FUNC_ADD = 6'b100000;
  localparam logic [5:0] FUNC_SUB = 6'b100010;
  localparam logic [5:0] FUNC_AND = 6'b100100;
  localparam logic [5:0] FUNC_OR  = 6'b100101;
  localparam logic [5:0] FUNC_SLT = 6'b101010;
  localparam logic [5:0] FUNC_NOR = 6'b100111;

  // ALU control decode
  always_comb begin
    aluctrl = CTRL_BAD;
    case (aluop)
      2'b00: aluctrl = CTRL_ADD;  // load/store/addi address or sum
      2'b01: aluctrl = CTRL_SUB;  // beq compare
      2'b10: begin
        case (func)
          FUNC_ADD: aluctrl = CTRL_ADD;
          FUNC_SUB: aluctrl = CTRL_SUB;
          FUNC_AND: aluctrl = CTRL_AND;
          FUNC_OR:  aluctrl = CTRL_OR;
          FUNC_SLT: aluctrl = CTRL_SLT;
          FUNC_NOR: aluctrl = CTRL_NOR;
          default:  aluctrl = CTRL_BAD;
        endcase
      end
      default: aluctrl = CTRL_OR;  // 2'b11: immediate logical
    endcase
  end

  // ALU; undefined codes (including the invalid-funct code) yield zero so the
  // zero flag is asserted for them.
  always_comb begin
    result = 32'd0;
    case (aluctrl)
      CTRL_AND: result = in1 & in2;
      CTRL_OR:  result = in1 | in2;
      CTRL_ADD: result = in1 + in2;
      CTRL_SUB: result = in1 - in2;
      CTRL_SLT: result = {31'd0, ($signed(in1) < $signed(in2))};
      CTRL_NOR: result = ~(in1 | in2);
      default:  result = 32'd0;
    endcase
  end

  assign zero     = (result == 32'd0);
  assign pc_plus4 = pc + PC_INC;

  // Output capture register; reset dominates the enable.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      result_q   <= 32'd0;
      zero_q     <= 1'b0;
      pc_plus4_q <= 32'd0;
    end else if (en) begin
      result_q   <= result;
      zero_q     <= zero;
      pc_plus4_q <= pc_plus4;
    end
  end

endmodule

// File: tb/tb_alu_exec_unit.sv
module tb_alu_exec_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        en;
  logic [1:0]  aluop;
  logic [5:0]  func;
  logic [31:0] in1;
  logic [31:0] in2;
  logic [31:0] pc;
  logic [3:0]  aluctrl;
  logic [31:0] result;
  logic        zero;
  logic [31:0] pc_plus4;
  logic [31:0] result_q;
  logic        zero_q;
  logic [31:0] pc_plus4_q;

  int checks = 0;
  int errors = 0;

  logic [5:0] rfunc [6];
  logic [3:0] rctrl [6];

  always #5 clk = ~clk;

  alu_exec_unit #(.PC_INC(32'd4)) dut (
    .clk(clk), .rst(rst), .en(en), .aluop(aluop), .func(func),
    .in1(in1), .in2(in2), .pc(pc), .aluctrl(aluctrl), .result(result),
    .zero(zero), .pc_plus4(pc_plus4), .result_q(result_q), .zero_q(zero_q),
    .pc_plus4_q(pc_plus4_q)
  );

  task automatic drive(input logic [1:0] op, input logic [5:0] f,
                       input logic [31:0] a, input logic [31:0] b);
    aluop = op; func = f; in1 = a; in2 = b;
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b0; en = 1'b1; aluop = 2'b00; func = 6'd0;
    in1 = 32'd1; in2 = 32'd2; pc = 32'h10;
    @(posedge clk); #1;
    checks++;
    if (result_q !== 32'd0 || zero_q !== 1'b0 || pc_plus4_q !== 32'd0) begin
      errors++;
      $display("FAIL reset: result_q=%h zero_q=%b pc_plus4_q=%h, required 0/0/0",
               result_q, zero_q, pc_plus4_q);
    end
    $display("reset: result_q=%h zero_q=%b pc_plus4_q=%h", result_q, zero_q, pc_plus4_q);
    @(negedge clk);
    en = 1'b0;
    rst = 1'b1;
  endtask

  task automatic test_decode();
    for (int i = 0; i < 6; i++) begin
      drive(2'b10, rfunc[i], 32'h5, 32'h3);
      checks++;
      if (aluctrl !== rctrl[i]) begin
        errors++;
        $display("FAIL decode_rtype func=%b: aluctrl=%b, required %b", rfunc[i], aluctrl, rctrl[i]);
      end
      $display("decode aluop=10 func=%b aluctrl=%b", rfunc[i], aluctrl);
    end
    drive(2'b10, 6'b000000, 32'h5, 32'h9);
    checks++;
    if (aluctrl !== 4'b1111 || result !== 32'd0 || zero !== 1'b1) begin
      errors++;
      $display("FAIL decode_invalid: aluctrl=%b result=%h zero=%b, required 1111/0/1",
               aluctrl, result, zero);
    end
    $display("decode invalid func: aluctrl=%b result=%h zero=%b", aluctrl, result, zero);
    drive(2'b00, 6'($urandom), 32'h5, 32'h3);
    checks++;
    if (aluctrl !== 4'b0010 || result !== 32'h8) begin
      errors++;
      $display("FAIL decode_op00: aluctrl=%b result=%h, required 0010/8", aluctrl, result);
    end
    $display("decode aluop=00 aluctrl=%b result=%h", aluctrl, result);
    drive(2'b01, 6'($urandom), 32'h5, 32'h3);
    checks++;
    if (aluctrl !== 4'b0110 || result !== 32'h2) begin
      errors++;
      $display("FAIL decode_op01: aluctrl=%b result=%h, required 0110/2", aluctrl, result);
    end
    $display("decode aluop=01 aluctrl=%b result=%h", aluctrl, result);
    drive(2'b11, 6'($urandom), 32'h5, 32'h3);
    checks++;
    if (aluctrl !== 4'b0001 || result !== 32'h7) begin
      errors++;
      $display("FAIL decode_op11: aluctrl=%b result=%h, required 0001/7", aluctrl, result);
    end
    $display("decode aluop=11 aluctrl=%b result=%h", aluctrl, result);
  endtask

  task automatic test_arith();
    drive(2'b10, 6'b100000, 32'hFFFFFFFF, 32'h1);
    checks++;
    if (result !== 32'd0 || zero !== 1'b1) begin
      errors++;
      $display("FAIL add_wrap: result=%h zero=%b, required 00000000/1", result, zero);
    end
    $display("add wrap: result=%h zero=%b", result, zero);
    drive(2'b10, 6'b100010, 32'd5, 32'd7);
    checks++;
    if (result !== 32'hFFFFFFFE || zero !== 1'b0) begin
      errors++;
      $display("FAIL sub_neg: result=%h zero=%b, required fffffffe/0", result, zero);
    end
    $display("sub 5-7: result=%h zero=%b", result, zero);
    drive(2'b01, 6'b111111, 32'h1234, 32'h1234);
    checks++;
    if (result !== 32'd0 || zero !== 1'b1) begin
      errors++;
      $display("FAIL beq_equal: result=%h zero=%b, required 00000000/1", result, zero);
    end
    $display("beq equal: result=%h zero=%b", result, zero);
  endtask

  task automatic test_slt_logic();
    drive(2'b10, 6'b101010, 32'hFFFFFFFF, 32'h1);
    checks++;
    if (result !== 32'd1) begin
      errors++;
      $display("FAIL slt_neg_lt_pos: result=%h, required 00000001", result);
    end
    $display("slt -1<1: result=%h", result);
    drive(2'b10, 6'b101010, 32'h1, 32'hFFFFFFFF);
    checks++;
    if (result !== 32'd0 || zero !== 1'b1) begin
      errors++;
      $display("FAIL slt_pos_lt_neg: result=%h zero=%b, required 00000000/1", result, zero);
    end
    $display("slt 1<-1: result=%h", result);
    drive(2'b10, 6'b100100, 32'hF0F0F0F0, 32'h0FF00FF0);
    checks++;
    if (result !== 32'h00F000F0) begin
      errors++;
      $display("FAIL and: result=%h, required 00f000f0", result);
    end
    $display("and: result=%h", result);
    drive(2'b10, 6'b100101, 32'hF0F0F0F0, 32'h0FF00FF0);
    checks++;
    if (result !== 32'hFFF0FFF0) begin
      errors++;
      $display("FAIL or: result=%h, required fff0fff0", result);
    end
    $display("or: result=%h", result);
    drive(2'b10, 6'b100111, 32'hF0F0F0F0, 32'h0FF00FF0);
    checks++;
    if (result !== 32'h000F000F) begin
      errors++;
      $display("FAIL nor: result=%h, required 000f000f", result);
    end
    $display("nor: result=%h", result);
  endtask

  task automatic test_pc();
    pc = 32'h00400000; #1;
    checks++;
    if (pc_plus4 !== 32'h00400004) begin
      errors++;
      $display("FAIL pc_inc: pc_plus4=%h, required 00400004", pc_plus4);
    end
    $display("pc 00400000 -> %h", pc_plus4);
    pc = 32'hFFFFFFFC; #1;
    checks++;
    if (pc_plus4 !== 32'h00000000) begin
      errors++;
      $display("FAIL pc_wrap: pc_plus4=%h, required 00000000", pc_plus4);
    end
    $display("pc fffffffc -> %h", pc_plus4);
  endtask

  task automatic test_register();
    @(negedge clk);
    en = 1'b1; aluop = 2'b00; func = 6'd0; in1 = 32'd3; in2 = 32'd4; pc = 32'h100;
    @(posedge clk); #1;
    checks++;
    if (result_q !== 32'd7 || zero_q !== 1'b0 || pc_plus4_q !== 32'h104) begin
      errors++;
      $display("FAIL capture: result_q=%h zero_q=%b pc_plus4_q=%h, required 7/0/104",
               result_q, zero_q, pc_plus4_q);
    end
    $display("capture: result_q=%h zero_q=%b pc_plus4_q=%h", result_q, zero_q, pc_plus4_q);
    @(negedge clk);
    en = 1'b0; in1 = 32'd10; in2 = 32'd20; pc = 32'h200;
    @(posedge clk); #1;
    checks++;
    if (result_q !== 32'd7 || pc_plus4_q !== 32'h104) begin
      errors++;
      $display("FAIL hold: result_q=%h pc_plus4_q=%h, required 7/104", result_q, pc_plus4_q);
    end
    $display("hold: result_q=%h pc_plus4_q=%h", result_q, pc_plus4_q);
  endtask

  task automatic test_async_reset();
    @(negedge clk);
    #2 rst = 1'b0;
    #1;
    checks++;
    if (result_q !== 32'd0 || zero_q !== 1'b0 || pc_plus4_q !== 32'd0) begin
      errors++;
      $display("FAIL async_reset: result_q=%h zero_q=%b pc_plus4_q=%h, required 0/0/0",
               result_q, zero_q, pc_plus4_q);
    end
    $display("async reset: result_q=%h zero_q=%b pc_plus4_q=%h", result_q, zero_q, pc_plus4_q);
    en = 1'b1; aluop = 2'b00; in1 = 32'd1; in2 = 32'd1; pc = 32'h300;
    #1;
    checks++;
    if (result !== 32'd2) begin
      errors++;
      $display("FAIL comb_during_reset: result=%h, required 2", result);
    end
    @(posedge clk); #1;
    checks++;
    if (result_q !== 32'd0 || pc_plus4_q !== 32'd0) begin
      errors++;
      $display("FAIL reset_dominates_en: result_q=%h pc_plus4_q=%h, required 0/0",
               result_q, pc_plus4_q);
    end
    $display("reset held with en=1: result_q=%h pc_plus4_q=%h", result_q, pc_plus4_q);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk); #1;
    checks++;
    if (result_q !== 32'd2 || zero_q !== 1'b0 || pc_plus4_q !== 32'h304) begin
      errors++;
      $display("FAIL resume: result_q=%h zero_q=%b pc_plus4_q=%h, required 2/0/304",
               result_q, zero_q, pc_plus4_q);
    end
    $display("resume: result_q=%h zero_q=%b pc_plus4_q=%h", result_q, zero_q, pc_plus4_q);
  endtask

  task automatic test_back_to_back();
    @(negedge clk);
    en = 1'b1; aluop = 2'b10; func = 6'b100000; in1 = 32'hFFFFFFFF; in2 = 32'h1; pc = 32'hFFFFFFFC;
    @(posedge clk); #1;
    checks++;
    if (result_q !== 32'd0 || zero_q !== 1'b1 || pc_plus4_q !== 32'd0) begin
      errors++;
      $display("FAIL b2b_first: result_q=%h zero_q=%b pc_plus4_q=%h, required 0/1/0",
               result_q, zero_q, pc_plus4_q);
    end
    $display("b2b first: result_q=%h zero_q=%b pc_plus4_q=%h", result_q, zero_q, pc_plus4_q);
    @(negedge clk);
    func = 6'b100111; in1 = 32'h0; in2 = 32'h0; pc = 32'h8;
    @(posedge clk); #1;
    checks++;
    if (result_q !== 32'hFFFFFFFF || zero_q !== 1'b0 || pc_plus4_q !== 32'hC) begin
      errors++;
      $display("FAIL b2b_second: result_q=%h zero_q=%b pc_plus4_q=%h, required ffffffff/0/c",
               result_q, zero_q, pc_plus4_q);
    end
    $display("b2b second: result_q=%h zero_q=%b pc_plus4_q=%h", result_q, zero_q, pc_plus4_q);
  endtask

  initial begin
    rfunc[0] = 6'b100000; rctrl[0] = 4'b0010;
    rfunc[1] = 6'b100010; rctrl[1] = 4'b0110;
    rfunc[2] = 6'b100100; rctrl[2] = 4'b0000;
    rfunc[3] = 6'b100101; rctrl[3] = 4'b0001;
    rfunc[4] = 6'b101010; rctrl[4] = 4'b0111;
    rfunc[5] = 6'b100111; rctrl[5] = 4'b1100;
    test_reset();
    test_decode();
    test_arith();
    test_slt_logic();
    test_pc();
    test_register();
    test_async_reset();
    test_back_to_back();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
